ripple_timer_ctrl: RTL and testbench

- Control FSM that sequences a WIDTH-bit up-counter datapath as a programmable interval timer.
- Handles start/stop/pause, a clock-enable prescaler, a terminal-count compare, and one-shot or auto-reload operation.
- Sits between software-style control strobes and the counter stages.
- Replaces free-running ripple counting with a single-clock, deterministic count sequence.

---
 rtl/ripple_timer_ctrl_pkg.sv | 15 +
 rtl/timer_count_core.sv | 48 ++++
 rtl/ripple_timer_ctrl.sv | 114 +++++++++++
 tb/tb_ripple_timer_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_timer_ctrl_pkg.sv
// Shared types and defaults for the ripple timer controller.
// State encoding is fixed so software-visible debug taps stay stable.
package ripple_timer_ctrl_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int PRESC_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/timer_count_core.sv
// Count and prescaler registers for the ripple timer.
// Advances count once every div+1 enabled cycles; flags the terminal step.
module timer_count_core
    import ripple_timer_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] div,
    input  logic [WIDTH-1:0]   term,
    output logic [WIDTH-1:0]   count,
    output logic               tick,
    output logic               adv,
    output logic               hit
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [WIDTH:0]     nxt_wide;

    assign nxt_wide = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};
    assign adv      = en && (presc_cnt == div);
    assign hit      = adv && (nxt_wide == {1'b0, term});

    // Prescaler and count registers; tick marks the cycle after an advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            presc_cnt <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= adv;
            if (clr) begin
                count     <= '0;
                presc_cnt <= '0;
            end else if (adv) begin
                count     <= nxt_wide[WIDTH-1:0];
                presc_cnt <= '0;
            end else if (en) begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ripple_timer_ctrl.sv
// Programmable interval timer controller.
// Sequences start/stop/pause/reload around timer_count_core.
module ripple_timer_ctrl
    import ripple_timer_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               auto_reload,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] presc,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               tick,
    output logic               done
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   term_q;
    logic [PRESC_W-1:0] div_q;
    logic               latch;
    logic               clr;
    logic               en;
    logic               adv;
    logic               hit;

    timer_count_core #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .div   (div_q),
        .term  (term_q),
        .count (count),
        .tick  (tick),
        .adv   (adv),
        .hit   (hit)
    );

    // State register plus terminal/divider captured on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            term_q  <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                term_q <= load_val;
                div_q  <= presc;
            end
        end
    end

    // Next state and datapath controls; stop > pause > advance.
    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    clr     = 1'b1;
                    state_d = (load_val == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else begin
                    en = 1'b1;
                    if (hit) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (auto_reload) begin
                    clr     = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ripple_timer_ctrl.sv
// Scoreboard bench for ripple_timer_ctrl.
// Model counts elapsed active cycles; count = elapsed / (presc+1).
module tb_ripple_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [3:0] load_val;
    logic [3:0] presc;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       done;

    always #5 clk = ~clk;

    ripple_timer_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .load_val    (load_val),
        .presc       (presc),
        .count       (count),
        .busy        (busy),
        .tick        (tick),
        .done        (done)
    );

    typedef struct packed {
        logic [3:0] c;
        logic       b;
        logic       t;
        logic       d;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: timing running, paused, finished, elapsed cycles.
    bit m_run;
    bit m_paused;
    bit m_fin;
    bit m_tick;
    int m_el;
    int m_cnt;
    int m_t;
    int m_d;

    function automatic void model_reset();
        m_run    = 0;
        m_paused = 0;
        m_fin    = 0;
        m_tick   = 0;
        m_el     = 0;
        m_cnt    = 0;
        m_t      = 0;
        m_d      = 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.c = 4'(m_cnt);
        e.b = m_run || m_fin;
        e.t = m_tick;
        e.d = m_fin;
        return e;
    endfunction

    function automatic void model_edge(input bit s, input bit p,
                                       input bit pa, input bit ar,
                                       input int lv, input int pr);
        m_tick = 0;
        if (m_fin) begin
            m_fin = 0;
            if (!p && ar) begin
                m_run = 1;
                m_el  = 0;
                m_cnt = 0;
            end
        end else if (m_run) begin
            if (p) begin
                m_run    = 0;
                m_paused = 0;
            end else if (m_paused) begin
                if (!pa) m_paused = 0;
            end else if (pa) begin
                m_paused = 1;
            end else begin
                m_el++;
                if (m_el % (m_d + 1) == 0) begin
                    m_cnt  = m_el / (m_d + 1);
                    m_tick = 1;
                    if (m_cnt == m_t) begin
                        m_run = 0;
                        m_fin = 1;
                    end
                end
            end
        end else if (s) begin
            m_t   = lv;
            m_d   = pr;
            m_el  = 0;
            m_cnt = 0;
            if (lv == 0) m_fin = 1;
            else         m_run = 1;
        end
    endfunction

    // Drive one cycle of stimulus and queue the response for the next edge.
    task automatic step(input bit s, input bit p, input bit pa,
                        input bit ar, input int lv, input int pr);
        @(negedge clk);
        rst         = 1'b0;
        start       = s;
        stop        = p;
        pause       = pa;
        auto_reload = ar;
        load_val    = 4'(lv);
        presc       = 4'(pr);
        model_edge(s, p, pa, ar, lv, pr);
        q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Monitor: compare every edge's outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ({count, busy, tick, done} !== e) begin
                    bad++;
                    $display("FAIL out@%0t: got c=%0d b=%0b t=%0b d=%0b want c=%0d b=%0b t=%0b d=%0b",
                             $time, count, busy, tick, done,
                             e.c, e.b, e.t, e.d);
                end
            end
        end
    end

    initial begin
        bit pa_lvl;
        bit hit;
        int s, p, ar, lv, pr;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        auto_reload = 1'b0;
        load_val    = '0;
        presc       = '0;
        model_reset();
        #1;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        q.push_back(model_out());

        // basic count
        step(1, 0, 0, 0, 5, 0);
        idle(8);
        // prescaler
        step(1, 0, 0, 0, 3, 2);
        idle(12);
        // pause
        step(1, 0, 0, 0, 5, 0);
        idle(1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
        idle(8);
        // auto-reload then stop
        step(1, 0, 0, 1, 2, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        idle(3);
        // zero terminal
        step(1, 0, 0, 0, 0, 0);
        idle(3);
        // start while running, start+stop in idle
        step(1, 0, 0, 0, 6, 1);
        idle(3);
        step(1, 0, 0, 0, 2, 0);
        idle(12);
        step(1, 1, 0, 0, 2, 0);
        idle(4);

        // async reset mid-count
        step(1, 0, 0, 0, 9, 2);
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            step(0, 0, 0, 0, 0, 0);
            hit = (m_cnt == 3) && m_run && (m_el % (m_d + 1) != 0);
        end
        chk("reach_mid", int'(hit), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tick", tick, 0);
        chk("arst_done", done, 0);
        model_reset();
        @(negedge clk);
        q.push_back(model_out());
        step(1, 0, 0, 0, 4, 1);
        idle(12);

        // randomized traffic
        pa_lvl = 0;
        for (int i = 0; i < 2500; i++) begin
            s  = ($urandom % 6) == 0;
            p  = ($urandom % 50) == 0;
            if (($urandom % 10) == 0) pa_lvl = ~pa_lvl;
            ar = (($urandom % 3) == 0) && (m_t != 0);
            lv = (($urandom % 10) == 0) ? 15 : int'($urandom % 8);
            pr = int'($urandom % 3);
            step(s[0], p[0], pa_lvl, ar[0], lv, pr);
        end
        idle(2);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
